id_stage: RTL

//  MIPS decode stage; drives the EX stage inputs (Ins, Rdata1, Rdata2, Ed32, nextPC).

---
 rtl/mips_pkg.sv | 33 +++
 rtl/id_stage_reg_file.sv | 52 +++++
 rtl/id_stage.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// +-----------------------------------------------------------------------------+
// | mips_pkg : opcode constants, NOP word and link register for the ID stage    |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

package mips_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;
    localparam logic [4:0]  REG_RA   = 5'd31;

    function automatic logic is_branch(input logic [5:0] op);
        return (op == OP_REGIMM) || (op == OP_BEQ) || (op == OP_BNE) ||
               (op == OP_BLEZ)   || (op == OP_BGTZ);
    endfunction

endpackage

`default_nettype wire

// File: rtl/id_stage_reg_file.sv
// +-----------------------------------------------------------------------------+
// | reg_file : 2-read/1-write GPR file, $0 hardwired, write-through bypass      |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module reg_file #(
    parameter int DW   = 32,
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [AW-1:0] raddr1_i,
    input  logic [AW-1:0] raddr2_i,
    output logic [DW-1:0] rdata1_o,
    output logic [DW-1:0] rdata2_o,
    input  logic          wen_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i
);

    logic [DW-1:0] gpr_q [NREG];
    logic          w_wr_live;

    assign w_wr_live = wen_i && (waddr_i != '0);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < NREG; i++) gpr_q[i] <= '0;
        end else if (w_wr_live) begin
            gpr_q[waddr_i] <= wdata_i;
        end
    end

    // A write landing this cycle is forwarded so the reader never sees stale data.
    function automatic logic [DW-1:0] rd_port(input logic [AW-1:0] ra,
                                              input logic          wlive,
                                              input logic [AW-1:0] wa,
                                              input logic [DW-1:0] wd,
                                              input logic [DW-1:0] stored);
        if (ra == '0)                  return '0;
        else if (wlive && (wa == ra))  return wd;
        else                           return stored;
    endfunction

    assign rdata1_o = rd_port(raddr1_i, w_wr_live, waddr_i, wdata_i, gpr_q[raddr1_i]);
    assign rdata2_o = rd_port(raddr2_i, w_wr_live, waddr_i, wdata_i, gpr_q[raddr2_i]);

endmodule

`default_nettype wire

// File: rtl/id_stage.sv
// +-----------------------------------------------------------------------------+
// | id_stage : MIPS decode stage -- GPR read, immediate extend, ID/EX register  |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module id_stage
    import mips_pkg::*;
#(
    parameter int          DW      = 32,
    parameter int          NREG    = 32,
    parameter logic [31:0] RST_NOP = NOP_WORD
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DW-1:0]           InsIn,
    input  logic [DW-1:0]           nextPCIn,
    input  logic                    ValidIn,
    input  logic                    Stall,
    input  logic                    Flush,
    input  logic                    Wen,
    input  logic [$clog2(NREG)-1:0] Waddr,
    input  logic [DW-1:0]           Wdata,
    output logic [DW-1:0]           Ins,
    output logic [DW-1:0]           Rdata1,
    output logic [DW-1:0]           Rdata2,
    output logic [DW-1:0]           Ed32,
    output logic [DW-1:0]           nextPC,
    output logic [4:0]              Wreg,
    output logic                    ValidOut
);

    logic [5:0]    w_op;
    logic [DW-1:0] w_rd1, w_rd2;
    logic [DW-1:0] w_sext;

    logic [DW-1:0] ins_d, rd1_d, rd2_d, ed32_d, npc_d;
    logic [4:0]    wreg_d;
    logic          valid_d;

    logic [DW-1:0] ins_q, rd1_q, rd2_q, ed32_q, npc_q;
    logic [4:0]    wreg_q;
    logic          valid_q;

    assign w_op   = InsIn[31:26];
    assign w_sext = {{16{InsIn[15]}}, InsIn[15:0]};

    reg_file #(.DW(DW), .NREG(NREG)) u_reg_file (
        .CLK      (CLK),
        .RST      (RST),
        .raddr1_i (InsIn[25:21]),
        .raddr2_i (InsIn[20:16]),
        .rdata1_o (w_rd1),
        .rdata2_o (w_rd2),
        .wen_i    (Wen),
        .waddr_i  (Waddr),
        .wdata_i  (Wdata)
    );

    always_comb begin
        ins_d   = RST_NOP;
        rd1_d   = '0;
        rd2_d   = '0;
        ed32_d  = '0;
        npc_d   = '0;
        wreg_d  = '0;
        valid_d = 1'b0;
        // A bubble loads the same NOP/zero image as a flush.
        if (ValidIn) begin
            valid_d = 1'b1;
            ins_d   = InsIn;
            rd1_d   = w_rd1;
            rd2_d   = w_rd2;
            npc_d   = nextPCIn;

            if (w_op == OP_RTYPE)                      ed32_d = {27'b0, InsIn[10:6]};
            else if (w_op == OP_J || w_op == OP_JAL)   ed32_d = {nextPCIn[31:28], InsIn[25:0], 2'b00};
            else if (is_branch(w_op))                  ed32_d = {w_sext[29:0], 2'b00};
            else if (w_op == OP_ANDI || w_op == OP_ORI ||
                     w_op == OP_XORI)                  ed32_d = {16'b0, InsIn[15:0]};
            else if (w_op == OP_LUI)                   ed32_d = {InsIn[15:0], 16'b0};
            else                                       ed32_d = w_sext;

            if (w_op == OP_RTYPE)                      wreg_d = InsIn[15:11];
            else if (w_op == OP_JAL)                   wreg_d = REG_RA;
            else if (w_op == OP_SW || w_op == OP_J ||
                     is_branch(w_op))                  wreg_d = '0;
            else                                       wreg_d = InsIn[20:16];
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ins_q   <= RST_NOP;
            rd1_q   <= '0;
            rd2_q   <= '0;
            ed32_q  <= '0;
            npc_q   <= '0;
            wreg_q  <= '0;
            valid_q <= 1'b0;
        end else if (Flush) begin
            ins_q   <= RST_NOP;
            rd1_q   <= '0;
            rd2_q   <= '0;
            ed32_q  <= '0;
            npc_q   <= '0;
            wreg_q  <= '0;
            valid_q <= 1'b0;
        end else if (!Stall) begin
            ins_q   <= ins_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            ed32_q  <= ed32_d;
            npc_q   <= npc_d;
            wreg_q  <= wreg_d;
            valid_q <= valid_d;
        end
    end

    assign Ins      = ins_q;
    assign Rdata1   = rd1_q;
    assign Rdata2   = rd2_q;
    assign Ed32     = ed32_q;
    assign nextPC   = npc_q;
    assign Wreg     = wreg_q;
    assign ValidOut = valid_q;

endmodule

`default_nettype wire
